// File: rtl/dsp48a1_share_arbiter.sv
// Round-robin arbiter time-sharing one dsp48a1_inst between N_REQ requesters,
// with a PIPE_LAT-cycle drain window after each burst so results reach the old owner.
module dsp48a1_share_arbiter #(
    parameter int N_REQ    = 4,
    parameter int INS_W    = 92,
    parameter int PIPE_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*INS_W-1:0]   dsp_ins_flat_req,
    output logic [N_REQ-1:0]         gnt,
    output logic [INS_W-1:0]         dsp_ins_flat,
    output logic                     busy,
    output logic [2:0]               owner_id
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;

    localparam logic [7:0] DRAIN_INIT = (PIPE_LAT > 0) ? 8'(PIPE_LAT - 1) : 8'd0;
    localparam logic [2:0] LAST_IDX   = 3'(N_REQ - 1);

    // First requesting index found when searching upward from p, wrapping modulo N_REQ.
    function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] r, input logic [2:0] p);
        logic [2:0] w;
        logic       hit;
        int         idx;
        w   = p;
        hit = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(p) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            for (int j = 0; j < N_REQ; j++) begin
                if (!hit && (j == idx) && r[j]) begin
                    w   = 3'(j);
                    hit = 1'b1;
                end
            end
        end
        return w;
    endfunction

    function automatic logic [N_REQ-1:0] one_hot(input logic [2:0] i);
        logic [N_REQ-1:0] o;
        for (int j = 0; j < N_REQ; j++) o[j] = (3'(j) == i);
        return o;
    endfunction

    state_t           state, state_nxt;
    logic [2:0]       owner, owner_nxt;
    logic [2:0]       ptr, ptr_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [N_REQ-1:0] gnt_nxt;

    logic             any_req;
    logic             owner_req;
    logic [2:0]       rel_ptr;
    logic [2:0]       win;
    logic [2:0]       win_rel;
    logic [INS_W-1:0] owner_slice;

    assign any_req   = |req;
    assign owner_req = |(req & one_hot(owner));
    assign rel_ptr   = (owner == LAST_IDX) ? 3'd0 : owner + 3'd1;
    assign win       = rr_pick(req, ptr);
    assign win_rel   = rr_pick(req, rel_ptr);

    always_comb begin
        owner_slice = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (3'(i) == owner) owner_slice = dsp_ins_flat_req[i*INS_W +: INS_W];
        end
    end

    // An owner that has dropped req gets the NOP word even while gnt is still up.
    always_comb begin
        dsp_ins_flat = '0;
        if (state == S_GRANT && owner_req) dsp_ins_flat = owner_slice;
    end

    assign busy     = (state != S_IDLE);
    assign owner_id = owner;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt = S_GRANT;
                    owner_nxt = win;
                    gnt_nxt   = one_hot(win);
                end
            end
            S_GRANT: begin
                if (!owner_req) begin
                    gnt_nxt = '0;
                    ptr_nxt = rel_ptr;
                    // Without a pipeline to drain, hand over immediately using the advanced pointer.
                    if (PIPE_LAT == 0) begin
                        if (any_req) begin
                            owner_nxt = win_rel;
                            gnt_nxt   = one_hot(win_rel);
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        state_nxt = S_DRAIN;
                        cnt_nxt   = DRAIN_INIT;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt == 8'd0) begin
                    if (any_req) begin
                        state_nxt = S_GRANT;
                        owner_nxt = win;
                        gnt_nxt   = one_hot(win);
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            owner <= 3'd0;
            ptr   <= 3'd0;
            cnt   <= 8'd0;
            gnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
        end
    end

endmodule

// File: tb/tb_dsp48a1_share_arbiter.sv
// Bench for dsp48a1_share_arbiter: two builds (PIPE_LAT=2 and 0) against a
// grant/drain reference model, plus directed literal expectations.
module tb_dsp48a1_share_arbiter;

    localparam int N = 4;
    localparam int W = 92;

    logic           clk     = 1'b0;
    logic           reset   = 1'b0;
    logic [N-1:0]   req     = '0;
    logic [N*W-1:0] bundles = '0;

    logic [N-1:0] gnt0, gnt1;
    logic [W-1:0] ins0, ins1;
    logic         busy0, busy1;
    logic [2:0]   oid0, oid1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dsp48a1_share_arbiter #(.N_REQ(N), .INS_W(W), .PIPE_LAT(2)) u_lat2 (
        .clk(clk), .reset(reset), .req(req), .dsp_ins_flat_req(bundles),
        .gnt(gnt0), .dsp_ins_flat(ins0), .busy(busy0), .owner_id(oid0)
    );

    dsp48a1_share_arbiter #(.N_REQ(N), .INS_W(W), .PIPE_LAT(0)) u_lat0 (
        .clk(clk), .reset(reset), .req(req), .dsp_ins_flat_req(bundles),
        .gnt(gnt1), .dsp_ins_flat(ins1), .busy(busy1), .owner_id(oid1)
    );

    // Reference model: who holds the DSP, how many drain cycles remain, where the search starts.
    typedef struct {
        bit on;
        int own;
        int ptr;
        int drain;
    } mst_t;

    mst_t m0 = '{1'b0, 0, 0, 0};
    mst_t m1 = '{1'b0, 0, 0, 0};

    function automatic mst_t mdl_pick(input mst_t s, input logic [N-1:0] r);
        mst_t n;
        n = s;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (s.ptr + k) % N;
            if (!n.on && r[idx]) begin
                n.on  = 1'b1;
                n.own = idx;
            end
        end
        return n;
    endfunction

    function automatic mst_t mdl_next(input mst_t s, input logic [N-1:0] r, input int lat);
        mst_t n;
        n = s;
        if (s.on) begin
            if (!r[s.own]) begin
                n.on    = 1'b0;
                n.ptr   = (s.own + 1) % N;
                n.drain = lat;
                if (lat == 0) n = mdl_pick(n, r);
            end
        end else if (s.drain > 0) begin
            n.drain = s.drain - 1;
            if (n.drain == 0) n = mdl_pick(n, r);
        end else begin
            n = mdl_pick(n, r);
        end
        return n;
    endfunction

    function automatic logic [N-1:0] exp_gnt(input mst_t s);
        logic [N-1:0] g;
        g = '0;
        if (s.on) g[s.own] = 1'b1;
        return g;
    endfunction

    function automatic logic [W-1:0] exp_ins(input mst_t s, input logic [N-1:0] r,
                                             input logic [N*W-1:0] b);
        if (s.on && r[s.own]) return b[s.own*W +: W];
        return '0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0 <= '{1'b0, 0, 0, 0};
            m1 <= '{1'b0, 0, 0, 0};
        end else begin
            m0 <= mdl_next(m0, req, 2);
            m1 <= mdl_next(m1, req, 0);
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("lat2_gnt",    W'(gnt0),  W'(exp_gnt(m0)));
        chk("lat2_ins",    ins0,      exp_ins(m0, req, bundles));
        chk("lat2_busy",   W'(busy0), W'(m0.on || m0.drain > 0));
        chk("lat2_owner",  W'(oid0),  W'(m0.own));
        chk("lat2_onehot", W'($onehot0(gnt0)), W'(1));
        chk("lat0_gnt",    W'(gnt1),  W'(exp_gnt(m1)));
        chk("lat0_ins",    ins1,      exp_ins(m1, req, bundles));
        chk("lat0_busy",   W'(busy1), W'(m1.on));
        chk("lat0_owner",  W'(oid1),  W'(m1.own));
        chk("lat0_onehot", W'($onehot0(gnt1)), W'(1));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_bundles();
        for (int i = 0; i < N; i++) bundles[i*W +: W] = W'({$urandom, $urandom, $urandom});
    endtask

    int           rr_exp [5] = '{0, 1, 2, 3, 0};
    int           gap;
    bit           found;
    logic [N-1:0] e_gnt;

    initial begin
        rand_bundles();
        req = 4'b1111;
        repeat (10) cyc();
        @(negedge clk);
        chk("rst_gnt",  W'(gnt0),  W'(0));
        chk("rst_ins",  ins0,      W'(0));
        chk("rst_busy", W'(busy0), W'(0));
        cyc();
        reset = 1'b1;
        cyc();
        @(negedge clk);
        chk("first_gnt",   W'(gnt0), W'(4'b0001));
        chk("first_owner", W'(oid0), W'(0));
        cyc();
        req = '0;
        repeat (4) cyc();

        // Single burst by requester 2.
        bundles[2*W +: W] = W'(92'h123);
        req = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            cyc();
            @(negedge clk);
            chk("burst_gnt", W'(gnt0), W'(4'b0100));
            chk("burst_ins", ins0,     W'(92'h123));
        end
        cyc();
        req = '0;
        @(negedge clk);
        chk("release_gnt", W'(gnt0), W'(4'b0100));
        chk("release_ins", ins0,     W'(0));
        for (int c = 0; c < 2; c++) begin
            cyc();
            @(negedge clk);
            chk("drain_busy", W'(busy0), W'(1));
            chk("drain_gnt",  W'(gnt0),  W'(0));
            chk("drain_ins",  ins0,      W'(0));
        end
        cyc();
        @(negedge clk);
        chk("idle_busy", W'(busy0), W'(0));

        // Round-robin rotation with everyone requesting.
        cyc();
        reset = 1'b0;
        req   = 4'b1111;
        rand_bundles();
        cyc();
        reset = 1'b1;
        gap   = 0;
        for (int g = 0; g < 5; g++) begin
            found = 1'b0;
            for (int t = 0; t < 12 && !found; t++) begin
                cyc();
                gap++;
                @(negedge clk);
                if (gnt0 != '0) found = 1'b1;
            end
            e_gnt = '0;
            e_gnt[rr_exp[g]] = 1'b1;
            chk("rr_owner", W'(gnt0), W'(e_gnt));
            if (g > 0) chk("rr_gap", W'(gap), W'(3));
            repeat (3) cyc();
            req[rr_exp[g]] = 1'b0;
            cyc();
            req[rr_exp[g]] = 1'b1;
            gap = 1;
        end
        cyc();
        req = '0;
        repeat (6) cyc();

        // A request arriving during drain waits for the window to close.
        req = 4'b1000;
        cyc();
        @(negedge clk);
        chk("cont_gnt3", W'(gnt0), W'(4'b1000));
        cyc();
        req = '0;
        cyc();
        req = 4'b0010;
        @(negedge clk);
        chk("cont_d1_gnt",  W'(gnt0),  W'(0));
        chk("cont_d1_busy", W'(busy0), W'(1));
        cyc();
        @(negedge clk);
        chk("cont_d2_gnt", W'(gnt0), W'(0));
        cyc();
        @(negedge clk);
        chk("cont_gnt1", W'(gnt0), W'(4'b0010));
        cyc();
        req = '0;
        repeat (5) cyc();

        // Asynchronous reset in the middle of a grant.
        req = 4'b0100;
        cyc();
        @(negedge clk);
        chk("areset_pre_gnt", W'(gnt0), W'(4'b0100));
        cyc();
        #2 reset = 1'b0;
        #1;
        chk("areset_gnt",  W'(gnt0),  W'(0));
        chk("areset_ins",  ins0,      W'(0));
        chk("areset_busy", W'(busy0), W'(0));
        cyc();
        req = 4'b0101;
        cyc();
        reset = 1'b1;
        cyc();
        @(negedge clk);
        chk("areset_ptr0", W'(gnt0), W'(4'b0001));

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            cyc();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            end
            rand_bundles();
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b0;
                #6 reset = 1'b1;
            end
        end

        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
